adder_checker: RTL and testbench
================================

Name: adder_checker

Overview:
- Built-in self-test engine for the 16-bit adder lab. It is the response side of the operand-stimulus interface.
- Drives operand pairs A/B into the ripple, carry-select and carry-lookahead adders in parallel.
- Waits a fixed settle time, then checks each adder's {CO,Sum} against an internal golden A+B.
- Accumulates pass/fail status for display on the board LEDs/hex.

Parameters:
- NUM_VECTORS, 256: total vectors per run (>=4). The first 4 are directed; the rest are pseudo-random.
- SETTLE_CYCLES, 2: cycles waited after operands change before sampling adder outputs (>=1).
- SEED_A, 16'hACE1: LFSR seed for operand A. Must be nonzero.
- SEED_B, 16'h1D2C: LFSR seed for operand B. Must be nonzero.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  run request; rising edge detected internally
- Sum_RC  in  16  ripple adder sum
- CO_RC  in  1  ripple adder carry-out
- Sum_CSA  in  16  carry-select adder sum
- CO_CSA  in  1  carry-select adder carry-out
- Sum_CLA  in  16  carry-lookahead adder sum
- CO_CLA  in  1  carry-lookahead adder carry-out
- A  out  16  operand A, registered
- B  out  16  operand B, registered
- Busy  out  1  run in progress
- Done  out  1  run complete; held until next start or reset
- Pass  out  1  valid when Done; 1 iff Err_Count==0
- Err_Count  out  16  count of failing (vector, adder) checks; saturates at 16'hFFFF
- Fail_Mask  out  3  sticky per-adder failure flags {CLA,CSA,RC}
- First_A  out  16  operand A of the first failing vector
- First_B  out  16  operand B of the first failing vector

Behaviour:
- Reset low (async): state IDLE. A, B, Busy, Done, Pass, Err_Count, Fail_Mask, First_A, First_B all 0. LFSRs reload their seeds. Vector index 0. Start edge detector cleared.
- Start edge = Start high this cycle and low the previous cycle. Level-held Start triggers exactly once.
- FSM states: IDLE, LOAD, SETTLE, CHECK, DONE.
- IDLE or DONE + start edge -> LOAD.
  - Clears Err_Count, Fail_Mask, First_A, First_B, Done and Pass.
  - Sets index to 0 and reloads the LFSR seeds.
  - Busy=1 from the next cycle.
- LOAD (1 cycle): register A/B for the current index.
  - Index 0..3 are directed: 3333/4444, 8888/8888, 6789/ABCD, 1234/5678.
  - Index >=4: current LFSR values; both LFSRs then advance one step.
  - LFSR is 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - LOAD -> SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles with A/B stable, then -> CHECK.
- CHECK (1 cycle): golden = 17-bit {1'b0,A}+{1'b0,B}. Each adder fails if {CO_x,Sum_x} != golden.
  - Err_Count += number of failing adders (0..3), saturating.
  - Fail_Mask |= failing bits.
  - First_A/First_B capture A/B only if this is the first failing vector of the run.
  - Last index -> DONE, else index++ and -> LOAD.
- Per-vector period: SETTLE_CYCLES+2 cycles.
- Run length from start edge to Done=1: NUM_VECTORS*(SETTLE_CYCLES+2)+1 cycles.
- DONE: Busy=0, Done=1, Pass=(Err_Count==0). A/B hold the last vector.
- Start edge while Busy is ignored.
- Reset mid-run aborts immediately to the reset values. There is no partial result.
- Golden and compare logic are internal only. The block never trusts any adder output as its reference.

Decomposition:
- Package adder_test_pkg holds:
  - state enum
  - the 4 directed operand pairs as a constant array
  - LFSR mask constant 16'hB400
- One sub-module, adder_checker_lfsr (16-bit Galois LFSR), with seed load, step enable and value out. Instantiated twice, for A and B.

Test Plan:
- All three adders correct, default params, start pulse -> Busy for 1025 cycles, then Done=1, Pass=1, Err_Count=0, Fail_Mask=000.
- CSA model with Sum bit0 inverted -> Done with Pass=0, Err_Count=256, Fail_Mask=010, First_A=3333, First_B=4444.
- CLA CO forced 0 only when A==8888 & B==8888 -> Err_Count=1, Fail_Mask=100, First_A=8888, First_B=8888.
- Check directed operand values:
  - A/B sampled in the first four LOAD states = 3333/4444, 8888/8888, 6789/ABCD, 1234/5678.
  - Fifth vector A=ACE1, B=1D2C.
- Reset low at cycle 300 of a run -> all outputs 0 asynchronously. After release, a new start reproduces the identical A/B sequence.
- Start held high through the whole run -> exactly one run. Start pulse while Busy -> no effect. Pulse after Done -> counters clear and a second run completes identically.

Source files
------------

// File: rtl/adder_test_pkg.sv
// Shared types and constants for the 16-bit adder self-test engine.
// Holds the FSM encoding, directed operand table and LFSR polynomial.
package adder_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } operand_pair_t;

    localparam int DIRECTED_COUNT = 4;

    localparam operand_pair_t DIRECTED [DIRECTED_COUNT] = '{
        '{a: 16'h3333, b: 16'h4444},
        '{a: 16'h8888, b: 16'h8888},
        '{a: 16'h6789, b: 16'hABCD},
        '{a: 16'h1234, b: 16'h5678}
    };

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

    function automatic logic [1:0] count_fails(input logic [2:0] f);
        return {1'b0, f[0]} + {1'b0, f[1]} + {1'b0, f[2]};
    endfunction

endpackage

// File: rtl/adder_checker_lfsr.sv
// 16-bit Galois LFSR operand generator.
// Reset and load both return the register to its seed.
import adder_test_pkg::*;

module adder_checker_lfsr #(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [15:0] value
);

    // seed load wins over stepping so a new run always starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/adder_checker.sv
// Self-test engine: drives A/B into three adders, waits, checks results.
// Golden sum is computed here; no adder output is trusted as reference.
import adder_test_pkg::*;

module adder_checker #(
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] SEED_A        = 16'hACE1,
    parameter logic [15:0] SEED_B        = 16'h1D2C
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] Sum_RC,
    input  logic        CO_RC,
    input  logic [15:0] Sum_CSA,
    input  logic        CO_CSA,
    input  logic [15:0] Sum_CLA,
    input  logic        CO_CLA,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [15:0] Err_Count,
    output logic [2:0]  Fail_Mask,
    output logic [15:0] First_A,
    output logic [15:0] First_B
);

    localparam int IDX_W = $clog2(NUM_VECTORS + 1);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t             state;
    state_t             state_next;
    logic               start_q;
    logic               start_edge;
    logic               run_start;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   settle_cnt;
    logic               settle_done;
    logic               last_vec;
    logic               directed;
    logic [15:0]        lfsr_a;
    logic [15:0]        lfsr_b;
    logic               lfsr_step;
    logic [16:0]        golden;
    logic [2:0]         fails;
    logic [16:0]        err_sum;

    assign start_edge  = Start & ~start_q;
    assign directed    = idx < IDX_W'(DIRECTED_COUNT);
    assign last_vec    = idx == IDX_W'(NUM_VECTORS - 1);
    assign settle_done = settle_cnt == CNT_W'(SETTLE_CYCLES - 1);
    assign lfsr_step   = (state == S_LOAD) && !directed;

    assign golden   = {1'b0, A} + {1'b0, B};
    assign fails[0] = {CO_RC, Sum_RC} != golden;
    assign fails[1] = {CO_CSA, Sum_CSA} != golden;
    assign fails[2] = {CO_CLA, Sum_CLA} != golden;
    assign err_sum  = {1'b0, Err_Count} + 17'(count_fails(fails));

    adder_checker_lfsr #(.SEED(SEED_A)) u_lfsr_a (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (run_start),
        .step  (lfsr_step),
        .value (lfsr_a)
    );

    adder_checker_lfsr #(.SEED(SEED_B)) u_lfsr_b (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (run_start),
        .step  (lfsr_step),
        .value (lfsr_b)
    );

    // previous Start level for rising-edge detection
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            start_q <= 1'b0;
        end else begin
            start_q <= Start;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; start is only honoured when no run is active
    always_comb begin
        state_next = state;
        run_start  = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    run_start  = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_done) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = last_vec ? S_DONE : S_LOAD;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // vector index and settle counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            if (run_start) begin
                idx <= '0;
            end else if (state == S_CHECK && !last_vec) begin
                idx <= idx + 1'b1;
            end
            if (state == S_LOAD) begin
                settle_cnt <= '0;
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // operand registers: directed table first, LFSR values afterwards
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            A <= '0;
            B <= '0;
        end else if (state == S_LOAD) begin
            if (directed) begin
                A <= DIRECTED[idx[1:0]].a;
                B <= DIRECTED[idx[1:0]].b;
            end else begin
                A <= lfsr_a;
                B <= lfsr_b;
            end
        end
    end

    // error accumulation; empty mask means no failure seen yet this run
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Err_Count <= '0;
            Fail_Mask <= '0;
            First_A   <= '0;
            First_B   <= '0;
        end else if (run_start) begin
            Err_Count <= '0;
            Fail_Mask <= '0;
            First_A   <= '0;
            First_B   <= '0;
        end else if (state == S_CHECK) begin
            Err_Count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            Fail_Mask <= Fail_Mask | fails;
            if (fails != 3'b000 && Fail_Mask == 3'b000) begin
                First_A <= A;
                First_B <= B;
            end
        end
    end

    // run status flags shown on the board
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Busy <= 1'b0;
            Done <= 1'b0;
            Pass <= 1'b0;
        end else if (run_start) begin
            Busy <= 1'b1;
            Done <= 1'b0;
            Pass <= 1'b0;
        end else if (state == S_DONE) begin
            Busy <= 1'b0;
            Done <= 1'b1;
            Pass <= Err_Count == 16'h0000;
        end
    end

endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker with behavioural adders and fault injection.
// Expected operands and error totals come from a vector-list model.
module tb_adder_checker;

    localparam int NV    = 256;
    localparam int SC    = 2;
    localparam int PER   = SC + 2;
    localparam int LIMIT = PER * NV + 50;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] Sum_RC, Sum_CSA, Sum_CLA;
    logic        CO_RC, CO_CSA, CO_CLA;
    logic [15:0] A, B;
    logic        Busy, Done, Pass;
    logic [15:0] Err_Count;
    logic [2:0]  Fail_Mask;
    logic [15:0] First_A, First_B;

    int          checks = 0;
    int          fails = 0;
    int          fault_mode = 0;
    logic [15:0] key_rc = 0, key_csa = 0, key_cla = 0;

    logic [15:0] exp_a [NV];
    logic [15:0] exp_b [NV];
    logic [15:0] obs_a [NV];
    logic [15:0] obs_b [NV];
    int          exp_err;
    logic [2:0]  exp_mask;
    logic [15:0] exp_fa, exp_fb;

    adder_checker #(
        .NUM_VECTORS  (NV),
        .SETTLE_CYCLES(SC),
        .SEED_A       (16'hACE1),
        .SEED_B       (16'h1D2C)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Sum_RC   (Sum_RC),
        .CO_RC    (CO_RC),
        .Sum_CSA  (Sum_CSA),
        .CO_CSA   (CO_CSA),
        .Sum_CLA  (Sum_CLA),
        .CO_CLA   (CO_CLA),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .Pass     (Pass),
        .Err_Count(Err_Count),
        .Fail_Mask(Fail_Mask),
        .First_A  (First_A),
        .First_B  (First_B)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // which: 0=RC 1=CSA 2=CLA
    function automatic logic [16:0] adder_out(input int which, input int mode,
                                              input logic [15:0] key,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (mode)
            1: if (which == 1) s = s ^ 17'h00001;
            2: if (which == 2 && a == 16'h8888 && b == 16'h8888) s[16] = 1'b0;
            3: if (((a ^ b ^ key) & 16'h0007) == 16'h0000) s = s ^ (17'h1 << which);
            default: ;
        endcase
        return s;
    endfunction

    always_comb begin
        {CO_RC, Sum_RC}   = adder_out(0, fault_mode, key_rc, A, B);
        {CO_CSA, Sum_CSA} = adder_out(1, fault_mode, key_csa, A, B);
        {CO_CLA, Sum_CLA} = adder_out(2, fault_mode, key_cla, A, B);
    end

    task automatic build_model();
        logic [15:0] ra, rb;
        logic [15:0] keys [3];
        logic [16:0] want;
        bit seen;
        keys[0] = key_rc;
        keys[1] = key_csa;
        keys[2] = key_cla;
        ra = 16'hACE1;
        rb = 16'h1D2C;
        for (int i = 0; i < NV; i++) begin
            case (i)
                0: begin exp_a[i] = 16'h3333; exp_b[i] = 16'h4444; end
                1: begin exp_a[i] = 16'h8888; exp_b[i] = 16'h8888; end
                2: begin exp_a[i] = 16'h6789; exp_b[i] = 16'hABCD; end
                3: begin exp_a[i] = 16'h1234; exp_b[i] = 16'h5678; end
                default: begin
                    exp_a[i] = ra;
                    exp_b[i] = rb;
                    ra = ra[0] ? ((ra >> 1) ^ 16'hB400) : (ra >> 1);
                    rb = rb[0] ? ((rb >> 1) ^ 16'hB400) : (rb >> 1);
                end
            endcase
        end
        exp_err = 0;
        exp_mask = 3'b000;
        exp_fa = 16'h0000;
        exp_fb = 16'h0000;
        seen = 0;
        for (int i = 0; i < NV; i++) begin
            want = exp_a[i] + exp_b[i];
            want = {1'b0, exp_a[i]} + {1'b0, exp_b[i]};
            for (int w = 0; w < 3; w++) begin
                if (adder_out(w, fault_mode, keys[w], exp_a[i], exp_b[i]) != want) begin
                    exp_err++;
                    exp_mask[w] = 1'b1;
                    if (!seen) begin
                        exp_fa = exp_a[i];
                        exp_fb = exp_b[i];
                    end
                end
            end
            if (exp_mask != 3'b000) seen = 1;
        end
        if (exp_err > 65535) exp_err = 65535;
    endtask

    task automatic do_run(input bit hold, input int poke_at);
        int j, k, busy_n, done_j;
        bit done_seen;
        build_model();
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        j = 0;
        k = 0;
        busy_n = 0;
        done_j = -1;
        done_seen = 0;
        while (!done_seen && j < LIMIT) begin
            @(negedge Clk);
            if (j == 0) begin
                if (!hold) Start = 1'b0;
                checks++;
                if (Busy !== 1'b1 || Done !== 1'b0 || Err_Count !== 16'h0 ||
                    Fail_Mask !== 3'b0 || First_A !== 16'h0 || First_B !== 16'h0) begin
                    fails++;
                    $display("FAIL run_clear: busy=%b done=%b err=%0d mask=%b fa=%h fb=%h, want 1 0 0 000 0000 0000",
                             Busy, Done, Err_Count, Fail_Mask, First_A, First_B);
                end
            end
            if (poke_at > 0 && j == poke_at) Start = 1'b1;
            if (poke_at > 0 && j == poke_at + 1 && !hold) Start = 1'b0;
            if (Busy === 1'b1) busy_n++;
            if (j >= 1 && (j - 1) % PER == 0 && k < NV) begin
                obs_a[k] = A;
                obs_b[k] = B;
                checks++;
                if (A !== exp_a[k] || B !== exp_b[k]) begin
                    fails++;
                    $display("FAIL operands[%0d]: got %h/%h, want %h/%h",
                             k, A, B, exp_a[k], exp_b[k]);
                end
                k++;
            end
            if (Done === 1'b1) begin
                done_seen = 1;
                done_j = j;
            end else begin
                @(posedge Clk);
                j++;
            end
        end
        checks++;
        if (done_j != PER * NV + 1) begin
            fails++;
            $display("FAIL done_latency: got %0d cycles, want %0d", done_j, PER * NV + 1);
        end
        checks++;
        if (busy_n != PER * NV + 1) begin
            fails++;
            $display("FAIL busy_length: got %0d cycles, want %0d", busy_n, PER * NV + 1);
        end
        checks++;
        if (Err_Count !== 16'(exp_err) || Fail_Mask !== exp_mask) begin
            fails++;
            $display("FAIL result: err=%0d mask=%b, want err=%0d mask=%b",
                     Err_Count, Fail_Mask, exp_err, exp_mask);
        end
        checks++;
        if (First_A !== exp_fa || First_B !== exp_fb) begin
            fails++;
            $display("FAIL first_fail: got %h/%h, want %h/%h", First_A, First_B, exp_fa, exp_fb);
        end
        checks++;
        if (Pass !== (exp_err == 0) || Busy !== 1'b0) begin
            fails++;
            $display("FAIL pass_flag: pass=%b busy=%b, want pass=%b busy=0",
                     Pass, Busy, exp_err == 0);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Start = 1'b0;
        #12;
        checks++;
        if ({A, B, Busy, Done, Pass, Err_Count, Fail_Mask, First_A, First_B} !== '0) begin
            fails++;
            $display("FAIL reset_state: a=%h b=%h busy=%b done=%b pass=%b err=%0d mask=%b fa=%h fb=%h, want all 0",
                     A, B, Busy, Done, Pass, Err_Count, Fail_Mask, First_A, First_B);
        end
        @(negedge Clk);
        Reset = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", Busy, Done);
        end
    endtask

    task automatic test_clean_run();
        fault_mode = 0;
        do_run(0, 0);
        checks++;
        if (Pass !== 1'b1 || Err_Count !== 16'd0 || Fail_Mask !== 3'b000) begin
            fails++;
            $display("FAIL clean_run: pass=%b err=%0d mask=%b, want 1 0 000", Pass, Err_Count, Fail_Mask);
        end
    endtask

    task automatic test_directed();
        logic [15:0] da [5];
        logic [15:0] db [5];
        da = '{16'h3333, 16'h8888, 16'h6789, 16'h1234, 16'hACE1};
        db = '{16'h4444, 16'h8888, 16'hABCD, 16'h5678, 16'h1D2C};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_a[i] !== da[i] || obs_b[i] !== db[i]) begin
                fails++;
                $display("FAIL directed[%0d]: got %h/%h, want %h/%h", i, obs_a[i], obs_b[i], da[i], db[i]);
            end
        end
    endtask

    task automatic test_csa_fault();
        fault_mode = 1;
        do_run(0, 0);
        checks++;
        if (Pass !== 1'b0 || Err_Count !== 16'd256 || Fail_Mask !== 3'b010 ||
            First_A !== 16'h3333 || First_B !== 16'h4444) begin
            fails++;
            $display("FAIL csa_fault: pass=%b err=%0d mask=%b first=%h/%h, want 0 256 010 3333/4444",
                     Pass, Err_Count, Fail_Mask, First_A, First_B);
        end
    endtask

    task automatic test_back_to_back();
        fault_mode = 0;
        do_run(0, 0);
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL rerun_seq[%0d]: got %h/%h, want %h/%h", i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]);
                break;
            end
        end
    endtask

    task automatic test_cla_fault();
        fault_mode = 2;
        do_run(0, 0);
        checks++;
        if (Err_Count !== 16'd1 || Fail_Mask !== 3'b100 ||
            First_A !== 16'h8888 || First_B !== 16'h8888) begin
            fails++;
            $display("FAIL cla_fault: err=%0d mask=%b first=%h/%h, want 1 100 8888/8888",
                     Err_Count, Fail_Mask, First_A, First_B);
        end
    endtask

    task automatic test_random_faults();
        for (int r = 0; r < 2; r++) begin
            key_rc = 16'($urandom);
            key_csa = 16'($urandom);
            key_cla = 16'($urandom);
            fault_mode = 3;
            do_run(0, 0);
        end
        fault_mode = 0;
    endtask

    task automatic test_reset_midrun();
        fault_mode = 1;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (300) @(posedge Clk);
        #2;
        checks++;
        if (Err_Count !== 16'd75 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL midrun_err: err=%0d busy=%b, want 75 1", Err_Count, Busy);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({A, B, Busy, Done, Pass, Err_Count, Fail_Mask, First_A, First_B} !== '0) begin
            fails++;
            $display("FAIL async_reset: a=%h b=%h busy=%b done=%b err=%0d mask=%b fa=%h fb=%h, want all 0",
                     A, B, Busy, Done, Err_Count, Fail_Mask, First_A, First_B);
        end
        @(negedge Clk);
        Reset = 1'b1;
        fault_mode = 0;
        do_run(0, 0);
    endtask

    task automatic test_start_held();
        fault_mode = 0;
        do_run(1, 0);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b1) begin
            fails++;
            $display("FAIL start_held: busy=%b done=%b, want 0 1", Busy, Done);
        end
        Start = 1'b0;
    endtask

    task automatic test_start_while_busy();
        fault_mode = 2;
        do_run(0, 300 + int'($urandom_range(0, 400)));
        fault_mode = 0;
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_directed();
        test_csa_fault();
        test_back_to_back();
        test_cla_fault();
        test_random_faults();
        test_reset_midrun();
        test_start_held();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
